pwm_multi_fader: RTL and testbench
==================================

// Module: pwm_multi_fader
// PURPOSE
//  N-channel PWM LED fader, parametrised in duty width, fade rate and channel count.
//  One shared PWM counter and one shared fade prescaler; each channel keeps its own duty and direction.
//  Per-channel mode selects hold, ramp-up, ramp-down or breathe, with an end-of-ramp done pulse.
//  Sits between the board's control logic and the LED pins; one instance drives a full LED bank.
// PARAMETERS
//  N_CH      4      number of LED channels
//  WIDTH     8      duty / PWM counter width; MAX = 2**WIDTH-1
//  FADE_DIV  10000  clk cycles per fade tick (>=2)
//  STEP      1      duty change per fade tick (1..MAX)
// PORTS
//  clk        in   1         system clock
//  rst        in   1         synchronous, active-high reset
//  en         in   N_CH      per-channel enable; 0 freezes duty/dir and forces led low
//  mode       in   2*N_CH    per-channel mode, ch i = mode[2i+1:2i]
//  led        out  N_CH      registered PWM output
//  dir        out  N_CH      registered direction, 1 = rising (debug)
//  done       out  N_CH      1-cycle pulse on the tick a ramp saturates
//  fade_tick  out  1         registered 1-cycle pulse per fade period
// BEHAVIOUR
//  Reset: pwm_cnt=0, prescaler=0, duty=0, dir=1, led=0, done=0, fade_tick=0.
//  pwm_cnt: free-running, MAX wraps to 0; period 2**WIDTH clk.
//  Prescaler: counts 0..FADE_DIV-1. On reaching FADE_DIV-1 it wraps to 0 and fade_tick=1 next cycle.
//  Duty updates happen in the cycle fade_tick is high. All updates saturate at 0 and MAX; no wrap.
//  Modes (2-bit):
//   HOLD=0: duty unchanged.
//   UP=1: duty=min(duty+STEP,MAX); dir=1.
//   DOWN=2: duty=max(duty-STEP,0); dir=0.
//   BREATHE=3: move duty by STEP in direction dir.
//   UP/DOWN done: pulses on the tick duty first reaches MAX (UP) or 0 (DOWN).
//   UP/DOWN at the bound: further ticks hold duty with no pulse.
//  BREATHE turnaround: duty reaching MAX on a tick flips dir to 0 on that same tick.
//   Duty reaching 0 flips dir to 1. Full cycle = 2*ceil(MAX/STEP) ticks, no repeated endpoint.
//  Mode change takes effect at the next fade tick; duty is kept across mode changes.
//  led = (pwm_cnt < duty_eff), registered: 1 clk latency.
//   duty_eff=0 gives led always 0; duty_eff=MAX gives led high MAX of 2**WIDTH cycles.
//  en=0: duty/dir/done frozen and led=0 from the next cycle. en 0->1 resumes from the frozen duty.
//  Simultaneous rst and tick: rst wins. Mid-operation rst returns every state to the reset values.
// CONFIGURATION
//  PWM_MULTI_FADER_GAMMA_EN defined:
//   duty_eff = (duty*duty) >> WIDTH, a 2*WIDTH-bit product truncated to WIDTH bits.
//   The product is registered, so led latency becomes 2 clk after a duty change.
//   For duty=MAX, duty_eff=MAX-1.
//  PWM_MULTI_FADER_GAMMA_EN undefined: duty_eff = duty (linear), no extra register.
// STRUCTURE
//  Package pwm_fader_pkg: mode encoding constants MODE_HOLD/UP/DOWN/BREATHE and the 2-bit mode type.
//  Top level: shared pwm_cnt, prescaler, fade_tick generation.
//  Sub-module pwm_fade_channel, instantiated N_CH times via generate.
//   Holds duty/dir/done state, the mode update logic, the optional gamma stage and the led compare register.
// TESTING  (WIDTH=4, FADE_DIV=3, STEP=1, N_CH=2 unless stated)
//  rst held 2 clk then released -> all outputs 0 and dir=1; fade_tick first high 3 clk after release.
//  ch0 BREATHE from 0 -> duty 0,1..15,14..0,1; dir falls on the tick duty hits 15.
//   dir rises on the tick duty hits 0; period 30 ticks.
//  ch1 UP -> done pulses once at duty=15; 5 more ticks give no pulse and duty stays 15.
//   Switch to DOWN -> done pulses once at duty=0.
//  Duty held at 5 (HOLD) -> led high exactly 5 of every 16 clk; duty 0 -> never high.
//   Duty 15 -> high 15 of 16.
//  STEP=4, BREATHE -> duty 0,4,8,12,15,11,7,3,0; no overflow and no underflow.
//  en0 dropped mid-ramp for 10 ticks -> led0 low, duty0 unchanged, ch1 unaffected.
//   en0 raised -> ramp continues from the same duty.
//  rst asserted mid-breathe on a tick cycle -> next cycle duty=0, dir=1, done=0.
//  GAMMA_EN build: duty=8 -> duty_eff=4, led high 4 of 16 clk.

Source files
------------

// File: rtl/pwm_fader_pkg.sv
// Shared definitions for the multi-channel PWM LED fader.
// Holds the per-channel mode encoding.
package pwm_fader_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD    = 2'd0,
        MODE_UP      = 2'd1,
        MODE_DOWN    = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

endpackage

// File: rtl/pwm_fade_channel.sv
// One fader channel: duty/direction state, ramp logic, led compare.
// Optional gamma stage enabled by PWM_MULTI_FADER_GAMMA_EN.
module pwm_fade_channel
    import pwm_fader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fade_tick,
    input  logic             en,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] pwm_cnt,
    output logic             led,
    output logic             dir,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [WIDTH:0]   MAX_X  = {1'b0, MAX};
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] duty_nxt;
    logic [WIDTH-1:0] duty_eff;
    logic             dir_nxt;
    logic             done_nxt;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH-1:0] up_sat;
    logic [WIDTH-1:0] dn_sat;

    // Saturating one-step moves in both directions
    always_comb begin
        up_sum = {1'b0, duty} + STEP_X;
        up_sat = (up_sum >= MAX_X) ? MAX : up_sum[WIDTH-1:0];
        dn_sat = ({1'b0, duty} <= STEP_X) ? '0 : duty - STEP_W;
    end

    // Next duty/dir/done, only on an enabled fade tick
    always_comb begin
        duty_nxt = duty;
        dir_nxt  = dir;
        done_nxt = 1'b0;
        if (fade_tick && en) begin
            unique case (mode)
                MODE_HOLD: begin
                end
                MODE_UP: begin
                    duty_nxt = up_sat;
                    dir_nxt  = 1'b1;
                    done_nxt = (duty != MAX) && (up_sat == MAX);
                end
                MODE_DOWN: begin
                    duty_nxt = dn_sat;
                    dir_nxt  = 1'b0;
                    done_nxt = (duty != '0) && (dn_sat == '0);
                end
                MODE_BREATHE: begin
                    if (dir) begin
                        duty_nxt = up_sat;
                        dir_nxt  = (up_sat != MAX);
                    end else begin
                        duty_nxt = dn_sat;
                        dir_nxt  = (dn_sat == '0);
                    end
                end
            endcase
        end
    end

    // Channel state register
    always_ff @(posedge clk) begin
        if (rst) begin
            duty <= '0;
            dir  <= 1'b1;
            done <= 1'b0;
        end else begin
            duty <= duty_nxt;
            dir  <= dir_nxt;
            done <= done_nxt;
        end
    end

`ifdef PWM_MULTI_FADER_GAMMA_EN
    logic [WIDTH-1:0] gamma_q;

    // Squared duty, upper half kept: rough perceptual correction
    always_ff @(posedge clk) begin
        if (rst) begin
            gamma_q <= '0;
        end else begin
            gamma_q <= WIDTH'(((2*WIDTH)'(duty) * (2*WIDTH)'(duty)) >> WIDTH);
        end
    end

    assign duty_eff = gamma_q;
`else
    assign duty_eff = duty;
`endif

    // Registered PWM compare, forced low while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            led <= 1'b0;
        end else begin
            led <= en && (pwm_cnt < duty_eff);
        end
    end

endmodule

// File: rtl/pwm_multi_fader.sv
// N-channel PWM LED fader: shared PWM counter and fade prescaler.
// Build option PWM_MULTI_FADER_GAMMA_EN adds a squared-duty stage.
module pwm_multi_fader
    import pwm_fader_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int WIDTH    = 8,
    parameter int FADE_DIV = 10000,
    parameter int STEP     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   en,
    input  logic [2*N_CH-1:0] mode,
    output logic [N_CH-1:0]   led,
    output logic [N_CH-1:0]   dir,
    output logic [N_CH-1:0]   done,
    output logic              fade_tick
);

    localparam int PW = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(FADE_DIV - 1);

    logic [WIDTH-1:0] pwm_cnt;
    logic [PW-1:0]    presc;

    // Free-running PWM counter, prescaler and fade tick pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt   <= '0;
            presc     <= '0;
            fade_tick <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + WIDTH'(1);
            if (presc == PRESC_LAST) begin
                presc     <= '0;
                fade_tick <= 1'b1;
            end else begin
                presc     <= presc + PW'(1);
                fade_tick <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pwm_fade_channel #(
            .WIDTH (WIDTH),
            .STEP  (STEP)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .fade_tick (fade_tick),
            .en        (en[i]),
            .mode      (mode_t'(mode[2*i +: 2])),
            .pwm_cnt   (pwm_cnt),
            .led       (led[i]),
            .dir       (dir[i]),
            .done      (done[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_fader.sv
// Bench for pwm_multi_fader: two instances (STEP 1 and STEP 4),
// checked against a cycle-level behavioural model of the fader rules.
`timescale 1ns/1ps
module tb_pwm_multi_fader;

    localparam int MAXV = 15;
    localparam logic [1:0] H = 2'd0, U = 2'd1, D = 2'd2, B = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] en1, en4;
    logic [3:0] mode1, mode4;
    logic [1:0] led1, dir1, done1, led4, dir4, done4;
    logic       tick1, tick4;

    always #5 clk = ~clk;

    pwm_multi_fader #(.N_CH(2), .WIDTH(4), .FADE_DIV(3), .STEP(1)) d1 (
        .clk(clk), .rst(rst), .en(en1), .mode(mode1),
        .led(led1), .dir(dir1), .done(done1), .fade_tick(tick1));

    pwm_multi_fader #(.N_CH(2), .WIDTH(4), .FADE_DIV(3), .STEP(4)) d4 (
        .clk(clk), .rst(rst), .en(en4), .mode(mode4),
        .led(led4), .dir(dir4), .done(done4), .fade_tick(tick4));

    int checks = 0;
    int errors = 0;

    // model: cycles since reset, per-instance/per-channel state
    int m_n;
    int m_duty [2][2];
    int m_g    [2][2];
    bit m_dir  [2][2];
    bit m_done [2][2];
    bit m_led  [2][2];

    function automatic int eff_of(input int d);
`ifdef PWM_MULTI_FADER_GAMMA_EN
        return (d * d) >> 4;
`else
        return d;
`endif
    endfunction

    function automatic bit tick_at(input int n);
        return (n >= 3) && (n % 3 == 0);
    endfunction

    task automatic ramp(input int d, input int md, input bit dr, input int st,
                        output int nd, output bit ndr, output bit dn);
        int up, dw;
        up = (d + st > MAXV) ? MAXV : d + st;
        dw = (d - st < 0) ? 0 : d - st;
        nd = d; ndr = dr; dn = 1'b0;
        case (md)
            1: begin nd = up; ndr = 1'b1; dn = (d != MAXV) && (up == MAXV); end
            2: begin nd = dw; ndr = 1'b0; dn = (d != 0) && (dw == 0); end
            3: begin
                if (dr) begin nd = up; ndr = (up != MAXV); end
                else    begin nd = dw; ndr = (dw == 0);    end
            end
            default: ;
        endcase
    endtask

    // advance DUT and model by one clock; outputs settle 1ns after the edge
    task automatic cyc();
        int nd [2][2];
        int ng [2][2];
        bit ndr[2][2];
        bit ndn[2][2];
        bit nl [2][2];
        bit tk, r;
        tk = tick_at(m_n);
        r  = rst;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                bit e;
                int md, eff;
                e  = (i == 0) ? en1[c] : en4[c];
                md = (i == 0) ? int'(mode1[2*c +: 2]) : int'(mode4[2*c +: 2]);
`ifdef PWM_MULTI_FADER_GAMMA_EN
                eff = m_g[i][c];
`else
                eff = m_duty[i][c];
`endif
                nl[i][c]  = e && ((m_n % 16) < eff);
                ng[i][c]  = (m_duty[i][c] * m_duty[i][c]) >> 4;
                nd[i][c]  = m_duty[i][c];
                ndr[i][c] = m_dir[i][c];
                ndn[i][c] = 1'b0;
                if (tk && e)
                    ramp(m_duty[i][c], md, m_dir[i][c], (i == 0) ? 1 : 4,
                         nd[i][c], ndr[i][c], ndn[i][c]);
            end
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                m_duty[i][c] = r ? 0    : nd[i][c];
                m_g[i][c]    = r ? 0    : ng[i][c];
                m_dir[i][c]  = r ? 1'b1 : ndr[i][c];
                m_done[i][c] = r ? 1'b0 : ndn[i][c];
                m_led[i][c]  = r ? 1'b0 : nl[i][c];
            end
        end
        m_n = r ? 0 : m_n + 1;
        #1;
    endtask

    task automatic count_high(input int i, input int c, output int n);
        n = 0;
        repeat (16) begin
            cyc();
            if ((i == 0) ? led1[c] : led4[c]) n++;
        end
    endtask

    task automatic go_to(input int target);
        int guard;
        guard = 0;
        mode1[1:0] = (m_duty[0][0] < target) ? U : D;
        while (m_duty[0][0] != target && guard < 300) begin
            cyc();
            guard++;
        end
        mode1[1:0] = H;
        checks++;
        if (guard >= 300) begin
            errors++;
            $display("FAIL go_to timeout duty %0d target %0d", m_duty[0][0], target);
        end
    endtask

    task automatic test_reset();
        int w;
        rst = 1'b1; en1 = 2'b11; en4 = 2'b11; mode1 = '0; mode4 = '0;
        cyc(); cyc();
        checks += 4;
        if (led1 !== 2'b00 || led4 !== 2'b00) begin
            errors++; $display("FAIL reset_led got %b/%b exp 00", led1, led4);
        end
        if (done1 !== 2'b00 || done4 !== 2'b00) begin
            errors++; $display("FAIL reset_done got %b/%b exp 00", done1, done4);
        end
        if (dir1 !== 2'b11 || dir4 !== 2'b11) begin
            errors++; $display("FAIL reset_dir got %b/%b exp 11", dir1, dir4);
        end
        if (tick1 !== 1'b0 || tick4 !== 1'b0) begin
            errors++; $display("FAIL reset_tick got %b/%b exp 0", tick1, tick4);
        end
        rst = 1'b0;
        w = 0;
        while (tick1 !== 1'b1 && w < 10) begin
            cyc();
            w++;
        end
        checks++;
        if (w != 3) begin
            errors++; $display("FAIL first_tick got %0d clk exp 3", w);
        end
    endtask

    task automatic test_breathe();
        int f1[$];
        int f4[$];
        bit p1, p4;
        rst = 1'b1; cyc(); rst = 1'b0;
        en1 = 2'b11; en4 = 2'b11;
        mode1 = {H, B}; mode4 = {B, B};
        p1 = dir1[0]; p4 = dir4[0];
        for (int k = 0; k < 200; k++) begin
            cyc();
            for (int c = 0; c < 2; c++) begin
                checks += 4;
                if (dir1[c] !== m_dir[0][c]) begin
                    errors++; $display("FAIL breathe_dir1 ch%0d got %b exp %b", c, dir1[c], m_dir[0][c]);
                end
                if (led1[c] !== m_led[0][c]) begin
                    errors++; $display("FAIL breathe_led1 ch%0d got %b exp %b", c, led1[c], m_led[0][c]);
                end
                if (dir4[c] !== m_dir[1][c]) begin
                    errors++; $display("FAIL breathe_dir4 ch%0d got %b exp %b", c, dir4[c], m_dir[1][c]);
                end
                if (led4[c] !== m_led[1][c]) begin
                    errors++; $display("FAIL breathe_led4 ch%0d got %b exp %b", c, led4[c], m_led[1][c]);
                end
            end
            if (p1 && !dir1[0]) f1.push_back(k);
            if (p4 && !dir4[0]) f4.push_back(k);
            p1 = dir1[0]; p4 = dir4[0];
        end
        checks += 2;
        if (f1.size() < 2 || f1[1] - f1[0] != 90) begin
            errors++; $display("FAIL breathe_period1 falls %0d exp period 90 clk", f1.size());
        end
        if (f4.size() < 2 || f4[1] - f4[0] != 24) begin
            errors++; $display("FAIL breathe_period4 falls %0d exp period 24 clk", f4.size());
        end
    endtask

    task automatic test_updown();
        int p, n;
        rst = 1'b1; cyc(); rst = 1'b0;
        en1 = 2'b11; mode1 = {U, H}; mode4 = '0;
        p = 0;
        repeat (66) begin
            cyc();
            checks++;
            if (done1 !== {m_done[0][1], m_done[0][0]}) begin
                errors++; $display("FAIL up_done got %b exp %b%b", done1, m_done[0][1], m_done[0][0]);
            end
            if (done1[1]) p++;
        end
        checks++;
        if (p != 1) begin
            errors++; $display("FAIL up_pulses got %0d exp 1", p);
        end
        count_high(0, 1, n);
        checks++;
        if (n != eff_of(15)) begin
            errors++; $display("FAIL up_hold_max got %0d exp %0d", n, eff_of(15));
        end
        mode1 = {D, H};
        p = 0;
        repeat (60) begin
            cyc();
            checks++;
            if (done1 !== {m_done[0][1], m_done[0][0]}) begin
                errors++; $display("FAIL down_done got %b exp %b%b", done1, m_done[0][1], m_done[0][0]);
            end
            if (done1[1]) p++;
        end
        checks++;
        if (p != 1) begin
            errors++; $display("FAIL down_pulses got %0d exp 1", p);
        end
    endtask

    task automatic test_levels();
        int lv[4];
        int n;
        lv = '{5, 8, 0, 15};
        rst = 1'b1; cyc(); rst = 1'b0;
        en1 = 2'b11; mode1 = '0;
        foreach (lv[k]) begin
            go_to(lv[k]);
            repeat (4) cyc();
            count_high(0, 0, n);
            checks++;
            if (n != eff_of(lv[k])) begin
                errors++; $display("FAIL level_%0d got %0d high exp %0d", lv[k], n, eff_of(lv[k]));
            end
        end
    endtask

    task automatic test_enable();
        int d0, n;
        rst = 1'b1; cyc(); rst = 1'b0;
        en1 = 2'b11; mode1 = {U, U};
        repeat (20) cyc();
        d0 = m_duty[0][0];
        en1[0] = 1'b0;
        repeat (30) begin
            cyc();
            checks += 2;
            if (led1[0] !== 1'b0) begin
                errors++; $display("FAIL en_off_led got %b exp 0", led1[0]);
            end
            if (led1[1] !== m_led[0][1] || dir1[1] !== m_dir[0][1]) begin
                errors++; $display("FAIL en_other_ch got %b%b exp %b%b", led1[1], dir1[1], m_led[0][1], m_dir[0][1]);
            end
        end
        mode1[1:0] = H;
        en1[0] = 1'b1;
        repeat (3) cyc();
        count_high(0, 0, n);
        checks++;
        if (n != eff_of(d0)) begin
            errors++; $display("FAIL en_frozen_duty got %0d exp %0d", n, eff_of(d0));
        end
        mode1[1:0] = U;
        repeat (24) begin
            cyc();
            checks++;
            if (led1[0] !== m_led[0][0]) begin
                errors++; $display("FAIL en_resume_led got %b exp %b", led1[0], m_led[0][0]);
            end
        end
    endtask

    task automatic test_rst_mid();
        int g, n;
        rst = 1'b1; cyc(); rst = 1'b0;
        en1 = 2'b11; en4 = 2'b11; mode1 = {B, B}; mode4 = {B, B};
        repeat ($urandom_range(20, 80)) cyc();
        g = 0;
        while (!tick_at(m_n) && g < 5) begin cyc(); g++; end
        checks++;
        if (tick1 !== 1'b1) begin
            errors++; $display("FAIL rst_mid_align got %b exp 1", tick1);
        end
        rst = 1'b1; cyc(); rst = 1'b0;
        checks += 4;
        if (dir1 !== 2'b11 || dir4 !== 2'b11) begin
            errors++; $display("FAIL rst_mid_dir got %b/%b exp 11", dir1, dir4);
        end
        if (done1 !== 2'b00 || done4 !== 2'b00) begin
            errors++; $display("FAIL rst_mid_done got %b/%b exp 00", done1, done4);
        end
        if (led1 !== 2'b00 || led4 !== 2'b00) begin
            errors++; $display("FAIL rst_mid_led got %b/%b exp 00", led1, led4);
        end
        if (tick1 !== 1'b0) begin
            errors++; $display("FAIL rst_mid_tick got %b exp 0", tick1);
        end
        mode1 = '0;
        count_high(0, 0, n);
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL rst_mid_duty got %0d high exp 0", n);
        end
    endtask

    task automatic test_random();
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                en1   = 2'($urandom_range(0, 3) != 0) | (2'($urandom_range(0, 3) != 0) << 1);
                en4   = 2'($urandom_range(0, 3) != 0) | (2'($urandom_range(0, 3) != 0) << 1);
                mode1 = 4'($urandom);
                mode4 = 4'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
            cyc();
            rst = 1'b0;
            checks += 2;
            if (tick1 !== tick_at(m_n)) begin
                errors++; $display("FAIL rand_tick1 got %b exp %b", tick1, tick_at(m_n));
            end
            if (tick4 !== tick_at(m_n)) begin
                errors++; $display("FAIL rand_tick4 got %b exp %b", tick4, tick_at(m_n));
            end
            for (int c = 0; c < 2; c++) begin
                checks += 6;
                if (led1[c] !== m_led[0][c]) begin
                    errors++; $display("FAIL rand_led1 ch%0d got %b exp %b", c, led1[c], m_led[0][c]);
                end
                if (dir1[c] !== m_dir[0][c]) begin
                    errors++; $display("FAIL rand_dir1 ch%0d got %b exp %b", c, dir1[c], m_dir[0][c]);
                end
                if (done1[c] !== m_done[0][c]) begin
                    errors++; $display("FAIL rand_done1 ch%0d got %b exp %b", c, done1[c], m_done[0][c]);
                end
                if (led4[c] !== m_led[1][c]) begin
                    errors++; $display("FAIL rand_led4 ch%0d got %b exp %b", c, led4[c], m_led[1][c]);
                end
                if (dir4[c] !== m_dir[1][c]) begin
                    errors++; $display("FAIL rand_dir4 ch%0d got %b exp %b", c, dir4[c], m_dir[1][c]);
                end
                if (done4[c] !== m_done[1][c]) begin
                    errors++; $display("FAIL rand_done4 ch%0d got %b exp %b", c, done4[c], m_done[1][c]);
                end
            end
        end
    endtask

    initial begin
        m_n = 0;
        rst = 1'b1; en1 = '0; en4 = '0; mode1 = '0; mode4 = '0;
        @(negedge clk);
        test_reset();
        test_breathe();
        test_updown();
        test_levels();
        test_enable();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
